// File: rtl/wishbone_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wishbone_rr_arbiter
//  Purpose  : Two-master / one-slave Wishbone arbiter. Round-robin grant on
//             ties, no preemption, and a watchdog that terminates a strobe
//             the slave never answers by forcing err to the owning master.
//  Ports    :
//    clock, reset               bus clock, asynchronous active-high reset
//    mN_cyc/stb/we/sel/adr/dat_i master N request side (N = 0, 1)
//    mN_dat_o                   slave read data, broadcast to both masters
//    mN_ack/err/rty_o           terminations, only ever to the owner
//    s_cyc/stb/we/sel/adr/dat_o slave request side (owner's signals or 0)
//    s_dat_i, s_ack/err/rty_i   slave response side
//    grant                      one-hot owner: 01 = m0, 10 = m1, 00 = idle
//  Revision : 1.0 - initial release
// ============================================================================
module wishbone_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    // master 0
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic                    m0_rty_o,
    // master 1
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    m1_rty_o,
    // slave
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    // ownership
    output logic [1:0]              grant
);

    localparam int c_sel_width = DATA_WIDTH / 8;
    // A zero TIMEOUT would give a zero-width counter; keep one bit so the
    // declaration stays legal even though the watchdog is then removed.
    localparam int c_cnt_width = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // State codes are the grant encoding, so grant is the state register.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OWN0 = 2'b01,
        S_OWN1 = 2'b10
    } state_t;

    state_t r_state;
    logic   r_last;          // last master served; 1 after reset so m0 wins the first tie

    logic   w_own0;
    logic   w_own1;
    logic   w_slave_term;
    logic   w_wdog_expired;
    logic   w_force_err;

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // On a tie the master that was not served last wins.
                    if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
                        r_state <= S_OWN0;
                        r_last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        r_state <= S_OWN1;
                        r_last  <= 1'b1;
                    end
                end
                S_OWN0: begin
                    // Held until m0 releases cyc; handover is same-edge.
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            r_state <= S_OWN1;
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_OWN1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            r_state <= S_OWN0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant  = r_state;
    assign w_own0 = (r_state == S_OWN0);
    assign w_own1 = (r_state == S_OWN1);

    // ------------------------------------------------------------------
    // Slave request mux: owner's signals straight through, zeros when idle
    // ------------------------------------------------------------------
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (w_own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (w_own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Bus-timeout watchdog
    // ------------------------------------------------------------------
    assign w_slave_term = s_ack_i | s_err_i | s_rty_i;

    generate
        if (TIMEOUT > 0) begin : g_wdog_on
            logic [c_cnt_width-1:0] r_wdog_cnt;

            // Restarts after expiry, so a master still holding stb after
            // the forced err gets a fresh timeout window.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_wdog_cnt <= '0;
                end else if (!s_stb_o || w_slave_term || w_wdog_expired) begin
                    r_wdog_cnt <= '0;
                end else begin
                    r_wdog_cnt <= r_wdog_cnt + 1'b1;
                end
            end

            assign w_wdog_expired = (r_wdog_cnt == c_cnt_width'(TIMEOUT));
        end else begin : g_wdog_off
            assign w_wdog_expired = 1'b0;
        end
    endgenerate

    // A real slave response in the expiry cycle wins over the forced err.
    assign w_force_err = w_wdog_expired & ~w_slave_term;

    // ------------------------------------------------------------------
    // Responses: terminations only to the owner, data to both
    // ------------------------------------------------------------------
    assign m0_ack_o = w_own0 & s_ack_i;
    assign m0_err_o = w_own0 & (s_err_i | w_force_err);
    assign m0_rty_o = w_own0 & s_rty_i;
    assign m1_ack_o = w_own1 & s_ack_i;
    assign m1_err_o = w_own1 & (s_err_i | w_force_err);
    assign m1_rty_o = w_own1 & s_rty_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Keeps the byte-lane width tied to the data width for readers.
    logic [c_sel_width-1:0] w_sel_unused;
    assign w_sel_unused = s_sel_o;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wishbone_rr_arbiter
//  Purpose  : Directed bench for wishbone_rr_arbiter. Stimulus pushes the
//             expected terminations and grant changes (with their cycle
//             numbers) into queues; a negedge monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam logic [5:0] M0_ACK = 6'b000001;
    localparam logic [5:0] M0_ERR = 6'b000010;
    localparam logic [5:0] M0_RTY = 6'b000100;
    localparam logic [5:0] M1_ACK = 6'b001000;
    localparam logic [5:0] M1_ERR = 6'b010000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [DW/8-1:0] m0_sel_i = '0;
    logic [AW-1:0] m0_adr_i = '0;
    logic [DW-1:0] m0_dat_i = '0;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o;
    logic          m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [DW/8-1:0] m1_sel_i = '0;
    logic [AW-1:0] m1_adr_i = '0;
    logic [DW-1:0] m1_dat_i = '0;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [DW/8-1:0] s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i = '0;
    logic          s_ack_i = 0, s_err_i = 0, s_rty_i = 0;
    logic [1:0]    grant;

    always #5 clock = ~clock;

    wishbone_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant(grant)
    );

    typedef struct {
        int          cyc;
        logic [5:0]  term;
        logic [31:0] dat;
        logic [31:0] adr;
    } term_t;

    typedef struct {
        int          cyc;
        logic [1:0]  g;
    } grant_t;

    term_t  term_q[$];
    grant_t grant_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     cyc_cnt  = 0;
    logic [1:0] prev_grant = 2'b00;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic exp_term(input int c, input logic [5:0] t, input logic [31:0] d, input logic [31:0] a);
        term_t e;
        e.cyc = c; e.term = t; e.dat = d; e.adr = a;
        term_q.push_back(e);
    endtask

    task automatic exp_grant(input int c, input logic [1:0] g);
        grant_t e;
        e.cyc = c; e.g = g;
        grant_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        logic [5:0] t;
        term_t      e;
        grant_t     g;
        t = {m1_rty_o, m1_err_o, m1_ack_o, m0_rty_o, m0_err_o, m0_ack_o};

        while (term_q.size() > 0 && term_q[0].cyc < cyc_cnt) begin
            checks++; failures++;
            $display("FAIL term_missing cycle=%0d required_cycle=%0d required_term=%b",
                     cyc_cnt, term_q[0].cyc, term_q[0].term);
            void'(term_q.pop_front());
        end
        if (t != 6'b0) begin
            checks++;
            if (term_q.size() == 0) begin
                failures++;
                $display("FAIL term_unexpected cycle=%0d actual_term=%b", cyc_cnt, t);
            end else begin
                e = term_q.pop_front();
                if (e.cyc != cyc_cnt || e.term != t || m0_dat_o !== e.dat ||
                    m1_dat_o !== e.dat || s_adr_o !== e.adr) begin
                    failures++;
                    $display("FAIL term cycle=%0d/%0d term=%b/%b dat0=%h dat1=%h/%h adr=%h/%h",
                             cyc_cnt, e.cyc, t, e.term, m0_dat_o, m1_dat_o, e.dat, s_adr_o, e.adr);
                end
            end
        end

        while (grant_q.size() > 0 && grant_q[0].cyc < cyc_cnt) begin
            checks++; failures++;
            $display("FAIL grant_missing cycle=%0d required_cycle=%0d required_grant=%b",
                     cyc_cnt, grant_q[0].cyc, grant_q[0].g);
            void'(grant_q.pop_front());
        end
        if (grant !== prev_grant) begin
            checks++;
            if (grant_q.size() == 0) begin
                failures++;
                $display("FAIL grant_unexpected cycle=%0d actual=%b previous=%b", cyc_cnt, grant, prev_grant);
            end else begin
                g = grant_q.pop_front();
                if (g.cyc != cyc_cnt || g.g !== grant) begin
                    failures++;
                    $display("FAIL grant cycle=%0d/%0d actual=%b required=%b", cyc_cnt, g.cyc, grant, g.g);
                end
            end
            prev_grant = grant;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int owner;

        #1 reset = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        chk("reset_grant", {30'b0, grant}, 32'h0);
        chk("reset_s_cyc", {31'b0, s_cyc_o}, 32'h0);
        chk("reset_s_stb", {31'b0, s_stb_o}, 32'h0);
        chk("reset_terms", {26'b0, m1_rty_o, m1_err_o, m1_ack_o, m0_rty_o, m0_err_o, m0_ack_o}, 32'h0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Tie straight out of reset: m0 first, same-edge handover to m1,
        // then m0 re-requests while m1 owns and is granted after m1.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10; m0_sel_i = 4'hF;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20; m1_sel_i = 4'hF;
        exp_grant(cyc_cnt + 1, 2'b01);
        tick();
        s_ack_i = 1; s_dat_i = 32'h1111_1111;
        exp_term(cyc_cnt, M0_ACK, 32'h1111_1111, 32'h10);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        exp_grant(cyc_cnt + 1, 2'b10);
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clock);
        chk("handover_adr", s_adr_o, 32'h20);
        tick();
        s_ack_i = 1; s_dat_i = 32'h2222_2222;
        exp_term(cyc_cnt, M1_ACK, 32'h2222_2222, 32'h20);
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        exp_grant(cyc_cnt + 1, 2'b01);
        tick();
        s_ack_i = 1; s_dat_i = 32'h3333_3333;
        exp_term(cyc_cnt, M0_ACK, 32'h3333_3333, 32'h10);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        exp_grant(cyc_cnt + 1, 2'b00);
        repeat (3) tick();

        // Single master read of 0x100, acked in the 2nd slave-side stb cycle.
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h100;
        exp_grant(cyc_cnt + 1, 2'b01);
        @(negedge clock);
        chk("arb_latency_before", {31'b0, s_cyc_o}, 32'h0);
        tick();
        @(negedge clock);
        chk("arb_latency_after", {31'b0, s_cyc_o}, 32'h1);
        tick();
        s_ack_i = 1; s_dat_i = 32'hCAFE_0100;
        exp_term(cyc_cnt, M0_ACK, 32'hCAFE_0100, 32'h100);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        exp_grant(cyc_cnt + 1, 2'b00);
        repeat (3) tick();

        // Watchdog: slave silent, single err pulse TIMEOUT cycles after stb.
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h60; s_dat_i = 32'hDEAD_0000;
        exp_grant(cyc_cnt + 1, 2'b10);
        exp_term(cyc_cnt + 1 + TO, M1_ERR, 32'hDEAD_0000, 32'h60);
        repeat (8) tick();
        m1_cyc_i = 0; m1_stb_i = 0;
        exp_grant(cyc_cnt + 1, 2'b00);
        repeat (3) tick();

        // Watchdog: slave acks in the expiry cycle, ack wins, no err.
        m1_cyc_i = 1; m1_stb_i = 1;
        exp_grant(cyc_cnt + 1, 2'b10);
        repeat (1 + TO) tick();
        s_ack_i = 1; s_dat_i = 32'hBEEF_0004;
        exp_term(cyc_cnt, M1_ACK, 32'hBEEF_0004, 32'h60);
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        exp_grant(cyc_cnt + 1, 2'b00);
        repeat (3) tick();

        // Round-robin: both keep requesting, 1-beat cycles, 1-cycle gaps.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h40;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h50;
        exp_grant(cyc_cnt + 1, 2'b01);
        tick();
        for (int i = 0; i < 4; i++) begin
            owner = i % 2;
            if (i > 0) begin
                if (owner == 0) begin m1_cyc_i = 1; m1_stb_i = 1; end
                else begin m0_cyc_i = 1; m0_stb_i = 1; end
            end
            s_ack_i = 1; s_dat_i = 32'hF000_0000 + i;
            exp_term(cyc_cnt, (owner == 1) ? M1_ACK : M0_ACK, s_dat_i,
                     (owner == 1) ? 32'h50 : 32'h40);
            tick();
            s_ack_i = 0;
            if (owner == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
            else begin m1_cyc_i = 0; m1_stb_i = 0; end
            if (i < 3) begin
                exp_grant(cyc_cnt + 1, (owner == 1) ? 2'b01 : 2'b10);
            end else begin
                m0_cyc_i = 0; m0_stb_i = 0;
                exp_grant(cyc_cnt + 1, 2'b00);
            end
            tick();
        end
        repeat (2) tick();

        // Isolation: m1 strobes without cyc while m0 owns the bus.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h200;
        m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h300;
        exp_grant(cyc_cnt + 1, 2'b01);
        tick();
        @(negedge clock);
        chk("iso_adr", s_adr_o, 32'h200);
        tick();
        s_ack_i = 1; s_dat_i = 32'h5A5A_5A5A;
        exp_term(cyc_cnt, M0_ACK, 32'h5A5A_5A5A, 32'h200);
        @(negedge clock);
        chk("iso_we", {31'b0, s_we_o}, 32'h0);
        tick();
        s_ack_i = 0; s_rty_i = 1;
        exp_term(cyc_cnt, M0_RTY, 32'h5A5A_5A5A, 32'h200);
        tick();
        s_rty_i = 0; s_err_i = 1;
        exp_term(cyc_cnt, M0_ERR, 32'h5A5A_5A5A, 32'h200);
        tick();
        s_err_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m1_stb_i = 0; m1_we_i = 0;
        exp_grant(cyc_cnt + 1, 2'b00);
        repeat (3) tick();

        // Reset mid-transfer while m1 owns; afterwards a tie goes to m0.
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h70;
        exp_grant(cyc_cnt + 1, 2'b10);
        repeat (2) tick();
        m0_cyc_i = 1;
        exp_grant(cyc_cnt, 2'b00);
        reset = 1'b1;
        #1;
        chk("rst_mid_s_cyc", {31'b0, s_cyc_o}, 32'h0);
        chk("rst_mid_grant", {30'b0, grant}, 32'h0);
        chk("rst_mid_terms", {26'b0, m1_rty_o, m1_err_o, m1_ack_o, m0_rty_o, m0_err_o, m0_ack_o}, 32'h0);
        tick();
        reset = 1'b0;
        exp_grant(cyc_cnt + 1, 2'b01);
        tick();
        m0_cyc_i = 0;
        exp_grant(cyc_cnt + 1, 2'b10);
        tick();
        m1_cyc_i = 0; m1_stb_i = 0;
        exp_grant(cyc_cnt + 1, 2'b00);
        repeat (3) tick();

        @(negedge clock);
        chk("term_queue_drained", term_q.size(), 32'h0);
        chk("grant_queue_drained", grant_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
